// File: rtl/mtpsa_user_arbiter.sv
// mtpsa_user_arbiter
//   Packet-granular round-robin arbiter that merges the per-user AXI-Stream
//   outputs into one stream. An owner keeps the output from its first beat
//   through tlast, so packets are never interleaved. user_enable fences
//   tenants off at arbitration time only; a packet in flight always completes.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no owner; round-robin scan from last_ptr+1, all tready low
//   BUSY  | user sel owns the output until its tlast handshake
//
// Ports
//   axis_aclk, axis_rst           clock, synchronous active-high reset
//   s_axis_*                      flattened per-user input streams (user i at slice i)
//   m_axis_*                      merged output stream
//   user_enable                   admission mask, sampled only in IDLE
//   grant                         one-hot owner, 0 when idle
//   busy                          high while a packet is in flight
//   pkt_cnt_clr, pkt_cnt          per-user completed-packet counters (32 bit each),
//                                 present only when MTPSA_ARB_PKT_CNT_EN is defined
module mtpsa_user_arbiter #(
    parameter int N_USERS            = 8,
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 296
) (
    input  logic                                  axis_aclk,
    input  logic                                  axis_rst,
    input  logic [N_USERS*C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [N_USERS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [N_USERS*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [N_USERS-1:0]                    s_axis_tvalid,
    input  logic [N_USERS-1:0]                    s_axis_tlast,
    output logic [N_USERS-1:0]                    s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]        m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]         m_axis_tuser,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    input  logic                                  m_axis_tready,
    input  logic [N_USERS-1:0]                    user_enable,
    output logic [N_USERS-1:0]                    grant,
`ifdef MTPSA_ARB_PKT_CNT_EN
    input  logic                                  pkt_cnt_clr,
    output logic [N_USERS*32-1:0]                 pkt_cnt,
`endif
    output logic                                  busy
);

    localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(N_USERS);
    localparam logic [PTR_W:0]   N_EXT    = (PTR_W+1)'(N_USERS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_USERS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_n;
    logic [PTR_W-1:0]     sel, sel_n;
    logic [PTR_W-1:0]     last_ptr, last_ptr_n;
    logic [N_USERS-1:0]   grant_n;
    logic [N_USERS-1:0]   req;
    logic [PTR_W:0]       cand;
    logic [PTR_W-1:0]     win;
    logic                 found;
    logic [PTR_W-1:0]     mux_idx;
    logic                 done;

    assign req = s_axis_tvalid & user_enable;

    // Round-robin scan starting after last_ptr. cand is one bit wider than
    // the pointer so the wrap is an explicit compare, valid for any N_USERS.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= N_USERS; k++) begin
            cand = {1'b0, last_ptr} + (PTR_W+1)'(k);
            if (cand >= N_EXT)
                cand = cand - N_EXT;
            if (!found && req[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = cand[PTR_W-1:0];
            end
        end
    end

    // Outside BUSY the mux points at slice 0; only tvalid is forced low.
    assign mux_idx = (state == BUSY) ? sel : '0;

    always_comb begin
        m_axis_tdata  = s_axis_tdata[mux_idx*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
        m_axis_tkeep  = s_axis_tkeep[mux_idx*KEEP_W +: KEEP_W];
        m_axis_tuser  = s_axis_tuser[mux_idx*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
        m_axis_tlast  = s_axis_tlast[mux_idx];
        m_axis_tvalid = (state == BUSY) && s_axis_tvalid[mux_idx];
        s_axis_tready = '0;
        if (state == BUSY)
            s_axis_tready[sel] = m_axis_tready;
    end

    assign done = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign busy = (state == BUSY);

    always_comb begin
        state_n    = state;
        sel_n      = sel;
        last_ptr_n = last_ptr;
        grant_n    = grant;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n      = BUSY;
                    sel_n        = win;
                    grant_n      = '0;
                    grant_n[win] = 1'b1;
                end
            end
            BUSY: begin
                if (done) begin
                    state_n    = IDLE;
                    last_ptr_n = sel;
                    grant_n    = '0;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            state    <= IDLE;
            sel      <= '0;
            last_ptr <= LAST_IDX;
            grant    <= '0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            last_ptr <= last_ptr_n;
            grant    <= grant_n;
        end
    end

`ifdef MTPSA_ARB_PKT_CNT_EN
    // Clear beats a coincident increment; counters wrap naturally at 2^32.
    always_ff @(posedge axis_aclk) begin
        if (axis_rst || pkt_cnt_clr)
            pkt_cnt <= '0;
        else if (done)
            pkt_cnt[sel*32 +: 32] <= pkt_cnt[sel*32 +: 32] + 32'd1;
    end
`else
    // Counters not built; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_mtpsa_user_arbiter.sv
`timescale 1ns/1ps
module tb_mtpsa_user_arbiter;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int TW = 16;
    localparam int KW = DW / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*DW-1:0]   s_tdata;
    logic [N*KW-1:0]   s_tkeep;
    logic [N*TW-1:0]   s_tuser;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tlast;
    logic [N-1:0]      s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [TW-1:0]     m_tuser;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready = 1'b1;
    logic [N-1:0]      user_enable = 8'hFF;
    logic [N-1:0]      grant;
    logic              busy;
`ifdef MTPSA_ARB_PKT_CNT_EN
    logic              pkt_cnt_clr = 1'b0;
    logic [N*32-1:0]   pkt_cnt;
`endif

    logic [DW-1:0] d_data [N];
    logic [TW-1:0] d_user [N];
    logic [KW-1:0] d_keep [N];
    logic [N-1:0]  d_valid = '0;
    logic [N-1:0]  d_last  = '0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_tdata[i*DW +: DW] = d_data[i];
            s_tuser[i*TW +: TW] = d_user[i];
            s_tkeep[i*KW +: KW] = d_keep[i];
        end
        s_tvalid = d_valid;
        s_tlast  = d_last;
    end

    mtpsa_user_arbiter #(
        .N_USERS(N), .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TW)
    ) dut (
        .axis_aclk(clk), .axis_rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .user_enable(user_enable), .grant(grant),
`ifdef MTPSA_ARB_PKT_CNT_EN
        .pkt_cnt_clr(pkt_cnt_clr), .pkt_cnt(pkt_cnt),
`endif
        .busy(busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tu;
        logic [KW-1:0] keep;
        logic          last;
        int            user;
        int            gap;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    logic bp_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected beats for one packet; gap_first is the expected cycle distance
    // from the previous output beat to this packet's first beat (0 = unchecked).
    task automatic push_pkt(input int u, input int pkt, input int nb, input int gap_first, input int gap_rest);
        exp_t e;
        for (int b = 0; b < nb; b++) begin
            e.data = {u[7:0], pkt[7:0], b[15:0]};
            e.tu   = {u[7:0], pkt[7:0]};
            e.keep = u[KW-1:0];
            e.last = (b == nb - 1);
            e.user = u;
            e.gap  = (b == 0) ? gap_first : gap_rest;
            sbq.push_back(e);
        end
    endtask

    task automatic send_pkt(input int u, input int pkt, input int nb);
        int t;
        for (int b = 0; b < nb; b++) begin
            d_data[u]  = {u[7:0], pkt[7:0], b[15:0]};
            d_user[u]  = {u[7:0], pkt[7:0]};
            d_keep[u]  = u[KW-1:0];
            d_last[u]  = (b == nb - 1);
            d_valid[u] = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!s_tready[u] && t < 400);
            chk($sformatf("src_ready_u%0d", u), {63'd0, s_tready[u]}, 64'd1);
            if (!s_tready[u]) begin
                d_valid[u] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        d_valid[u] = 1'b0;
        d_last[u]  = 1'b0;
    endtask

    task automatic monitor();
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data  = '0;
        int            last_hs    = 0;
        logic [N-1:0]  exp_rdy;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_rdy = busy ? (grant & {N{m_tready}}) : '0;
                chk("tready_vector", {56'd0, s_tready}, {56'd0, exp_rdy});
                if (prev_stall && m_tvalid)
                    chk("stall_stable", {32'd0, m_tdata}, {32'd0, prev_data});
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
                if (m_tvalid && m_tready) begin
                    chk("sb_nonempty", {63'd0, sbq.size() != 0}, 64'd1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk("beat_data", {32'd0, m_tdata}, {32'd0, e.data});
                        chk("beat_tuser", {48'd0, m_tuser}, {48'd0, e.tu});
                        chk("beat_tkeep", {60'd0, m_tkeep}, {60'd0, e.keep});
                        chk("beat_tlast", {63'd0, m_tlast}, {63'd0, e.last});
                        chk("beat_grant", {56'd0, grant}, 64'd1 << e.user);
                        if (e.gap != 0)
                            chk("beat_gap", 64'(cyc - last_hs), 64'(e.gap));
                    end
                    last_hs = cyc;
                end
            end
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) break;
        end
        chk("drain_left", 64'(sbq.size()), 64'd0);
    endtask

    task automatic wait_grant(input int u);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (grant[u]) break;
        end
        chk($sformatf("grant_seen_u%0d", u), {63'd0, grant[u]}, 64'd1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            d_data[i] = '0;
            d_user[i] = '0;
            d_keep[i] = '0;
        end
        fork
            monitor();
        join_none

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_grant", {56'd0, grant}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_tready", {56'd0, s_tready}, 64'd0);
`ifdef MTPSA_ARB_PKT_CNT_EN
        chk("rst_cnt_u1", {32'd0, pkt_cnt[63:32]}, 64'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Round robin 0,3,5,0 with 1-cycle bubble between packets
        push_pkt(0, 0, 2, 0, 1);
        push_pkt(3, 0, 2, 2, 1);
        push_pkt(5, 0, 2, 2, 1);
        push_pkt(0, 1, 2, 2, 1);
        fork
            begin send_pkt(0, 0, 2); send_pkt(0, 1, 2); end
            send_pkt(3, 0, 2);
            send_pkt(5, 0, 2);
        join
        wait_drain();

        // Backpressure: user 2, 4 beats, ready toggling
        push_pkt(2, 0, 4, 0, 0);
        bp_on = 1'b1;
        fork
            begin send_pkt(2, 0, 4); bp_on = 1'b0; end
            while (bp_on) begin
                @(posedge clk);
                #1 if (bp_on) m_tready = ~m_tready;
            end
        join
        m_tready = 1'b1;
        wait_drain();

        // Enable mask: user 2 fenced, user 4 disabled mid-packet completes
        @(posedge clk);
        #1 user_enable = 8'hFB;
        d_data[2] = 32'hDEAD_0002; d_user[2] = 16'hDEAD; d_keep[2] = '1;
        d_last[2] = 1'b1; d_valid[2] = 1'b1;
        push_pkt(4, 0, 4, 0, 1);
        fork
            send_pkt(4, 0, 4);
            begin
                wait_grant(4);
                @(posedge clk);
                #1 user_enable = 8'hEB;
            end
        join
        wait_drain();
        d_data[4] = 32'hDEAD_0004; d_user[4] = 16'hBEEF;
        d_last[4] = 1'b1; d_valid[4] = 1'b1;
        repeat (10) @(negedge clk);
        chk("fenced_grant", {56'd0, grant}, 64'd0);
        chk("fenced_busy", {63'd0, busy}, 64'd0);
        d_valid[2] = 1'b0; d_valid[4] = 1'b0;
        d_last[2] = 1'b0; d_last[4] = 1'b0;
        @(posedge clk);
        #1 user_enable = 8'hFF;

        // Wrap-around: grant 7, then users 1 and 6 -> 1 first, then 6
        push_pkt(7, 0, 2, 0, 1);
        push_pkt(1, 0, 1, 2, 1);
        push_pkt(6, 0, 1, 2, 1);
        fork
            send_pkt(7, 0, 2);
            begin
                wait_grant(7);
                fork
                    send_pkt(1, 0, 1);
                    send_pkt(6, 0, 1);
                join
            end
        join
        wait_drain();

        // Lone requester re-granted after a single bubble
        push_pkt(3, 1, 1, 0, 1);
        push_pkt(3, 2, 1, 2, 1);
        send_pkt(3, 1, 1);
        send_pkt(3, 2, 1);
        wait_drain();

`ifdef MTPSA_ARB_PKT_CNT_EN
        @(posedge clk);
        #1 pkt_cnt_clr = 1'b1;
        @(posedge clk);
        #1 pkt_cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_cleared_u1", {32'd0, pkt_cnt[63:32]}, 64'd0);
        chk("cnt_cleared_u3", {32'd0, pkt_cnt[127:96]}, 64'd0);
        for (int p = 0; p < 5; p++) begin
            push_pkt(1, 10 + p, 1, 0, 1);
            send_pkt(1, 10 + p, 1);
        end
        wait_drain();
        chk("cnt_u1_five", {32'd0, pkt_cnt[63:32]}, 64'd5);
        chk("cnt_u0_zero", {32'd0, pkt_cnt[31:0]}, 64'd0);
        push_pkt(1, 20, 1, 0, 1);
        fork
            send_pkt(1, 20, 1);
            begin
                for (int t = 0; t < 200; t++) begin
                    @(negedge clk);
                    if (m_tvalid && m_tready && m_tlast && grant[1]) break;
                end
                pkt_cnt_clr = 1'b1;
                @(posedge clk);
                #1 pkt_cnt_clr = 1'b0;
            end
        join
        wait_drain();
        chk("cnt_clr_wins", {32'd0, pkt_cnt[63:32]}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
